// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder for a single-cycle core: word RAM plus an MMIO window
// holding GPIO, a 64-bit cycle counter, a saturating store counter and a TOHOST halt register.
module dmem_mmio_responder #(
    parameter int          MEM_WORDS   = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
    parameter logic [63:0] CYCLE_RESET = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] gpio_out,
    output logic        halted,
    output logic [31:0] exit_code
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS) << 2;
    localparam logic [29:0] MMIO_WORD = MMIO_BASE[31:2];

    typedef enum logic {RUN, HALT} state_t;

    state_t        state;
    logic [31:0]   mem [MEM_WORDS];
    logic [63:0]   cycle;
    logic [31:0]   store_cnt;

    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          sel_ram;
    logic          sel_gpio;
    logic          sel_clo;
    logic          sel_chi;
    logic          sel_tohost;
    logic          sel_scnt;
    logic          ram_we;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // RAM_BYTES is a multiple of 4, so comparing the full byte address is a word compare
    assign word_addr  = Addr[31:2];
    assign ram_idx    = Addr[AW+1:2];
    assign sel_ram    = (Addr < RAM_BYTES);
    assign sel_gpio   = (word_addr == MMIO_WORD);
    assign sel_clo    = (word_addr == MMIO_WORD + 30'd1);
    assign sel_chi    = (word_addr == MMIO_WORD + 30'd2);
    assign sel_tohost = (word_addr == MMIO_WORD + 30'd3);
    assign sel_scnt   = (word_addr == MMIO_WORD + 30'd4);
    assign ram_we     = MemWrite && sel_ram && (state == RUN);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= WriteData;
        end
    end

    // Combinational read: a same-cycle write is not visible until after the edge
    always_comb begin
        ReadData = 32'd0;
        if (sel_ram) begin
            ReadData = mem[ram_idx];
        end else if (sel_gpio) begin
            ReadData = gpio_out;
        end else if (sel_clo) begin
            ReadData = cycle[31:0];
        end else if (sel_chi) begin
            ReadData = cycle[63:32];
        end else if (sel_tohost) begin
            ReadData = exit_code;
        end else if (sel_scnt) begin
            ReadData = store_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            halted    <= 1'b0;
            exit_code <= 32'd0;
            gpio_out  <= 32'd0;
            cycle     <= CYCLE_RESET;
            store_cnt <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    cycle <= cycle + 64'd1;
                    if (MemWrite) begin
                        store_cnt <= sat_inc(store_cnt);
                    end
                    if (MemWrite && sel_gpio) begin
                        gpio_out <= WriteData;
                    end
                    if (MemWrite && sel_tohost) begin
                        state     <= HALT;
                        halted    <= 1'b1;
                        exit_code <= WriteData;
                    end
                end
                // Everything is frozen until reset
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM/MMIO decode, halt behaviour,
// counter wrap from preset reset values, and asynchronous reset.
module tb_dmem_mmio_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] gpio_out;
    logic        halted;
    logic [31:0] exit_code;

    logic [31:0] addr_b, rd_b, gpio_b, exit_b;
    logic        halted_b;
    logic [31:0] addr_c, rd_c, gpio_c, exit_c;
    logic        halted_c;

    int errors;
    int checks;
    int n_edges;

    dmem_mmio_responder dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .gpio_out(gpio_out),
        .halted(halted), .exit_code(exit_code)
    );

    dmem_mmio_responder #(.CYCLE_RESET(64'h0000_0000_FFFF_FFFE)) dut_b (
        .clk(clk), .reset(reset), .MemWrite(1'b0), .Addr(addr_b),
        .WriteData(32'd0), .ReadData(rd_b), .gpio_out(gpio_b),
        .halted(halted_b), .exit_code(exit_b)
    );

    dmem_mmio_responder #(.CYCLE_RESET(64'hFFFF_FFFF_FFFF_FFFF)) dut_c (
        .clk(clk), .reset(reset), .MemWrite(1'b0), .Addr(addr_c),
        .WriteData(32'd0), .ReadData(rd_c), .gpio_out(gpio_c),
        .halted(halted_c), .exit_code(exit_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_edges++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n_edges = 0;
        reset = 1'b0;
        MemWrite = 1'b0;
        Addr = 32'd0;
        WriteData = 32'd0;
        addr_b = 32'h1004;
        addr_c = 32'h1004;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_gpio", gpio_out, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_exit", exit_code, 32'd0);
        chk("b_rst_cycle_lo", rd_b, 32'hFFFF_FFFE);
        chk("c_rst_cycle_lo", rd_c, 32'hFFFF_FFFF);
        reset = 1'b1;

        // Counter wrap from preset reset values
        tick();
        chk("c_wrap_lo", rd_c, 32'd0);
        addr_c = 32'h1008;
        #1;
        chk("c_wrap_hi", rd_c, 32'd0);
        tick();
        chk("b_carry_lo", rd_b, 32'd0);
        addr_b = 32'h1008;
        #1;
        chk("b_carry_hi", rd_b, 32'd1);
        Addr = 32'h1004;
        #1;
        chk("a_cycle_lo", ReadData, 32'd2);

        // RAM read-during-write returns the old word
        Addr = 32'h10;
        WriteData = 32'h1111_1111;
        MemWrite = 1'b1;
        tick();
        WriteData = 32'hDEAD_BEEF;
        #1;
        chk("ram_old", ReadData, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        #1;
        chk("ram_new", ReadData, 32'hDEAD_BEEF);
        Addr = 32'h13;
        #1;
        chk("ram_lsb_ignored", ReadData, 32'hDEAD_BEEF);

        // GPIO and read-only cycle register
        Addr = 32'h1000;
        WriteData = 32'h1234;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        #1;
        chk("gpio_out", gpio_out, 32'h1234);
        chk("gpio_read", ReadData, 32'h1234);
        Addr = 32'h1004;
        WriteData = 32'h0000_FFFF;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        #1;
        chk("cycle_ro_drop", ReadData, 32'd6);
        Addr = 32'h1010;
        #1;
        chk("store_cnt_4", ReadData, 32'd4);
        Addr = 32'h1008;
        #1;
        chk("cycle_hi_0", ReadData, 32'd0);

        // Unmapped MMIO word
        Addr = 32'h1040;
        #1;
        chk("unmapped_rd", ReadData, 32'd0);
        WriteData = 32'hCAFE;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        #1;
        chk("unmapped_rd2", ReadData, 32'd0);
        chk("unmapped_gpio", gpio_out, 32'h1234);
        Addr = 32'h1010;
        #1;
        chk("store_cnt_5", ReadData, 32'd5);
        Addr = 32'h10;
        #1;
        chk("unmapped_ram", ReadData, 32'hDEAD_BEEF);

        // TOHOST halt and freeze
        Addr = 32'h0;
        WriteData = 32'h600D;
        MemWrite = 1'b1;
        tick();
        Addr = 32'h100C;
        WriteData = 32'd1;
        #1;
        chk("pre_halt", 32'(halted), 32'd0);
        tick();
        MemWrite = 1'b0;
        #1;
        chk("halted", 32'(halted), 32'd1);
        chk("exit_code", exit_code, 32'd1);
        chk("tohost_read", ReadData, 32'd1);
        Addr = 32'h1004;
        #1;
        chk("halt_cycle", ReadData, 32'd9);
        MemWrite = 1'b1;
        Addr = 32'h100C;
        WriteData = 32'd7;
        tick();
        Addr = 32'h0;
        WriteData = 32'h55;
        tick();
        Addr = 32'h1000;
        WriteData = 32'h99;
        tick();
        MemWrite = 1'b0;
        repeat (5) tick();
        chk("halt_exit_keep", exit_code, 32'd1);
        chk("halt_still", 32'(halted), 32'd1);
        chk("halt_gpio_keep", gpio_out, 32'h1234);
        Addr = 32'h0;
        #1;
        chk("halt_ram_keep", ReadData, 32'h600D);
        Addr = 32'h1004;
        #1;
        chk("halt_cycle_frozen", ReadData, 32'd9);
        Addr = 32'h1010;
        #1;
        chk("halt_store_frozen", ReadData, 32'd7);

        // Asynchronous reset between edges
        reset = 1'b0;
        #1;
        reset = 1'b1;
        n_edges = 0;
        Addr = 32'h1000;
        WriteData = 32'hA5;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        repeat (10) tick();
        chk("run_gpio", gpio_out, 32'hA5);
        Addr = 32'h1004;
        #1;
        chk("run_cycle", ReadData, 32'd11);
        Addr = 32'h1010;
        #1;
        chk("run_store", ReadData, 32'd1);
        reset = 1'b0;
        #1;
        chk("async_gpio", gpio_out, 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        chk("async_exit", exit_code, 32'd0);
        chk("async_store", ReadData, 32'd0);
        Addr = 32'h1004;
        #1;
        chk("async_cycle", ReadData, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
